// File: rtl/fft_twiddle_sched.sv
// Frame sequencer for the radix-2 DIF twiddle ROM: walks k and stage over log2(N) stages,
// issuing addr = (k << stage) mod N/2 one per enabled cycle with sync/done frame markers.
module fft_twiddle_sched #(
    parameter int N      = 128,
    parameter int LOGN   = $clog2(N),
    parameter int ADDR_W = LOGN - 1,
    parameter int STG_W  = (LOGN > 1) ? $clog2(LOGN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    input  logic              en,
    input  logic              abort,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_vld,
    output logic [STG_W-1:0]  stage,
    output logic              sync,
    output logic              done,
    output logic              busy
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(N / 2 - 1);
    localparam logic [STG_W-1:0]  S_LAST = STG_W'(LOGN - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] k, k_nxt;
    logic [STG_W-1:0]  s, s_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [STG_W-1:0]  stage_nxt;
    logic              vld_nxt, sync_nxt, done_nxt;
    logic [ADDR_W-1:0] addr_shift;

    // Shift in ADDR_W bits so the high bits fall off: this is the mod N/2 wrap.
    assign addr_shift = k << s;

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        s_nxt     = s;
        addr_nxt  = addr;
        stage_nxt = stage;
        vld_nxt   = 1'b0;
        sync_nxt  = 1'b0;
        done_nxt  = 1'b0;

        if (abort) begin
            state_nxt = IDLE;
            k_nxt     = '0;
            s_nxt     = '0;
            addr_nxt  = '0;
            stage_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = RUN;
                        k_nxt     = '0;
                        s_nxt     = '0;
                    end
                end
                RUN: begin
                    if (en) begin
                        addr_nxt  = addr_shift;
                        stage_nxt = s;
                        vld_nxt   = 1'b1;
                        sync_nxt  = (k == '0) && (s == '0);
                        if (k == K_LAST) begin
                            k_nxt = '0;
                            if (s == S_LAST) begin
                                // continuous is only looked at here, on the frame-end edge.
                                s_nxt = '0;
                                if (!continuous) begin
                                    done_nxt  = 1'b1;
                                    state_nxt = IDLE;
                                end
                            end else begin
                                s_nxt = s + 1'b1;
                            end
                        end else begin
                            k_nxt = k + 1'b1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            k        <= '0;
            s        <= '0;
            addr     <= '0;
            stage    <= '0;
            addr_vld <= 1'b0;
            sync     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            k        <= k_nxt;
            s        <= s_nxt;
            addr     <= addr_nxt;
            stage    <= stage_nxt;
            addr_vld <= vld_nxt;
            sync     <= sync_nxt;
            done     <= done_nxt;
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_fft_twiddle_sched.sv
// Scoreboard bench for fft_twiddle_sched (N=128): driver queues expected addresses, monitor checks them.
`timescale 1ns/1ps
module tb_fft_twiddle_sched;

    localparam int N     = 128;
    localparam int LOGN  = 7;
    localparam int AW    = 6;
    localparam int SW    = 3;
    localparam int FRAME = LOGN * N / 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic          en = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] addr;
    logic          addr_vld;
    logic [SW-1:0] stage;
    logic          sync;
    logic          done;
    logic          busy;

    fft_twiddle_sched #(.N(N), .LOGN(LOGN), .ADDR_W(AW), .STG_W(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .en         (en),
        .abort      (abort),
        .addr       (addr),
        .addr_vld   (addr_vld),
        .stage      (stage),
        .sync       (sync),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [SW-1:0] stage;
        logic          sync;
        logic          done;
    } exp_t;

    exp_t          q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            n_seen = 0;
    bit            hold_chk = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [SW-1:0] last_stage = '0;
    logic [8:0]    rec [0:4095];

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_frame(input int count, input bit done_last);
        exp_t e;
        for (int i = 0; i < count; i++) begin
            int s;
            int k;
            s = i / (N / 2);
            k = i % (N / 2);
            e.addr  = AW'((k << s) % (N / 2));
            e.stage = SW'(s);
            e.sync  = (i == 0);
            e.done  = done_last && (i == count - 1);
            q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_drain(input int bound);
        int c;
        c = 0;
        while (q.size() != 0 && c < bound) begin
            tick();
            c++;
        end
        check("drain_in_time", q.size(), 0);
    endtask

    // Monitor: pops one expected entry per presented address.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            if (addr_vld) begin
                if (n_seen < 4096) rec[n_seen] = {stage, addr};
                n_seen++;
                check("queue_has_entry", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("addr", addr, e.addr);
                    check("stage", stage, e.stage);
                    check("sync", sync, e.sync);
                    check("done", done, e.done);
                    if (e.done) check("busy_at_done", busy, 0);
                end
                last_addr  = addr;
                last_stage = stage;
            end else begin
                check("sync_without_vld", sync, 0);
                check("done_without_vld", done, 0);
                if (hold_chk) begin
                    check("hold_addr", addr, last_addr);
                    check("hold_stage", stage, last_stage);
                end
            end
        end
    end

    initial begin
        int base;
        int sidx[9] = '{0, 63, 64, 65, 127, 130, 199, 258, 447};
        int sval[9] = '{0, 63, 64, 66, 126, 136, 248, 288, 384};

        // Reset and idle
        repeat (3) tick();
        check("reset_outputs", {addr, addr_vld, stage, sync, done, busy}, 0);
        rst = 1'b0;
        repeat (10) begin
            tick();
            check("idle_outputs", {addr, addr_vld, stage, sync, done, busy}, 0);
        end

        // Single frame, en held high
        base = n_seen;
        en = 1'b1;
        push_frame(FRAME, 1'b1);
        do_start();
        wait_drain(1000);
        tick();
        check("single_vld_after", addr_vld, 0);
        check("single_busy_after", busy, 0);
        check("single_count", n_seen - base, FRAME);
        for (int i = 0; i < 9; i++) check("single_spot", rec[base + sidx[i]], sval[i]);

        // Enable gaps 1,0,0,1
        base = n_seen;
        hold_chk = 1'b1;
        push_frame(FRAME, 1'b1);
        do_start();
        begin
            int c;
            c = 0;
            while (q.size() != 0 && c < 3000) begin
                en = (c % 4 == 0) || (c % 4 == 3);
                tick();
                c++;
            end
            check("gap_drain_in_time", q.size(), 0);
        end
        tick();
        hold_chk = 1'b0;
        en = 1'b1;
        check("gap_count", n_seen - base, FRAME);
        check("gap_busy_after", busy, 0);

        // Continuous: two frames back to back, drop continuous during the second
        base = n_seen;
        push_frame(FRAME, 1'b0);
        push_frame(FRAME, 1'b1);
        continuous = 1'b1;
        do_start();
        repeat (460) tick();
        check("cont_no_bubble", n_seen - base, 459);
        check("cont_busy_mid", busy, 1);
        continuous = 1'b0;
        wait_drain(1000);
        tick();
        check("cont_count", n_seen - base, 2 * FRAME);
        check("cont_busy_after", busy, 0);
        check("cont_frame2_first", rec[base + FRAME], 0);

        // Abort after address 100
        base = n_seen;
        push_frame(100, 1'b0);
        do_start();
        repeat (100) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_vld", addr_vld, 0);
        check("abort_busy", busy, 0);
        check("abort_count", n_seen - base, 100);
        check("abort_queue", q.size(), 0);
        check("abort_last_stage", rec[base + 99] >> 6, 1);
        base = n_seen;
        push_frame(FRAME, 1'b1);
        do_start();
        wait_drain(1000);
        tick();
        check("post_abort_count", n_seen - base, FRAME);

        // Start while busy and on the frame-end edge is ignored
        base = n_seen;
        push_frame(FRAME, 1'b1);
        do_start();
        for (int j = 1; j <= FRAME; j++) begin
            tick();
            start = (j == 100) || (j == 200) || (j == FRAME - 1);
        end
        start = 1'b0;
        repeat (5) tick();
        check("ignored_start_busy", busy, 0);
        check("ignored_start_vld", addr_vld, 0);
        check("ignored_start_count", n_seen - base, FRAME);
        check("ignored_start_queue", q.size(), 0);

        // Start one cycle after done begins a new frame
        base = n_seen;
        push_frame(FRAME, 1'b1);
        do_start();
        repeat (FRAME) tick();
        check("done_visible", done, 1);
        push_frame(FRAME, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_busy", busy, 1);
        wait_drain(1500);
        tick();
        check("restart_count", n_seen - base, 2 * FRAME);
        check("restart_busy_after", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_twiddle_sched.md
# fft_twiddle_sched

Frame-level scheduler for the twiddle coefficient ROM of the N-point radix-2 DIF FFT pipeline. It runs a frame through all log2(N) stages, issues one ROM address per enabled cycle, and tags each address with its stage number. It also drives the frame sync and done markers used by the butterfly datapath. It replaces the free-running per-stage coefficient counters with a single start/enable/abort-controlled sequencer.

## Interface
- N, 128, FFT size; power of two, 8..1024
- LOGN, 7, log2(N); number of stages
- ADDR_W, 6, ROM address width = LOGN-1 (ROM depth N/2)
- STG_W, 3, stage index width, ceil(log2(LOGN))

- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a frame; sampled only in IDLE
- continuous  in  1  when high at end of frame, start the next frame immediately
- en  in  1  sample enable; one address issued per RUN cycle with en=1
- abort  in  1  return to IDLE next edge; overrides everything except rst
- addr  out  ADDR_W  twiddle ROM address
- addr_vld  out  1  addr/stage valid this cycle
- stage  out  STG_W  stage of the current address, 0..LOGN-1
- sync  out  1  high with the first address of each frame (stage 0, k=0)
- done  out  1  one-cycle pulse with the last address of a frame that does not continue
- busy  out  1  high while in RUN

## Operation
- Internal state: FSM {IDLE, RUN}, butterfly counter k (ADDR_W bits), stage counter s (STG_W bits).
- Address rule: addr = (k << s) mod N/2, i.e. the low ADDR_W bits of k·2^s. Compute it in ADDR_W bits and truncate the shifted value; no overflow flag.
- IDLE:
  - On start=1: go to RUN, k=0, s=0.
  - Outputs addr_vld, sync and done are 0.
- RUN, en=1, per edge:
  - Register addr from the current k and s, stage=s, addr_vld=1.
  - sync=1 iff k=0 and s=0.
  - Then advance: k=k+1.
  - If k=N/2-1: k=0 and s=s+1.
  - If k=N/2-1 and s=LOGN-1 (frame end): continuous=1 → s=0, stay RUN, no done. continuous=0 → done=1, go IDLE.
- RUN, en=0: addr_vld, sync and done are 0. Counters, addr and stage hold.
- continuous is sampled only at the frame-end edge. Deasserting it mid-frame finishes the current frame, then stops.
- start is ignored while busy, including start coinciding with the frame-end edge.
- abort=1 (any state): next edge → IDLE, k=0, s=0, addr_vld=0, sync=0, done=0. No done pulse. A simultaneous start is ignored.
- rst=1: same as abort. Reset values: addr=0, stage=0, addr_vld=0, sync=0, done=0, busy=0, FSM=IDLE.
- Frame length: LOGN·N/2 addresses (448 for N=128), independent of en gaps.

## Timing
- All outputs are registered; none has a combinational path from any input.
- Start latency:
  - start=1 at edge t (in IDLE) → busy=1 after t.
  - First address (addr_vld=1, sync=1) appears after edge t+1 if en=1 at t+1.
- Per address: one cycle from the en=1 edge to addr_vld. The ROM adds its own read latency downstream, and the stage tag is delayed by the datapath to match.
- done is asserted in the same cycle as the last addr_vld of the frame. busy falls after that same edge.
- Minimum IDLE dwell between non-continuous frames is 1 cycle, because start is sampled only in IDLE.
- Continuous mode: the sync of frame n+1 immediately follows the last address of frame n when en stays high. There is no bubble.

## Test plan
- Reset/idle: rst held 3 cycles, then start=0 for 10 cycles → all outputs 0, busy=0.
- Single frame, en=1 (N=128):
  - Pulse start → 448 consecutive addr_vld.
  - Stage 0: addr 0..63. Stage 1: 0,2,…,62,0,2,…,62. Stage 6: all 0.
  - sync on the first address only; done on the 448th with stage=6; busy drops next cycle.
- Enable gaps: en toggles 1,0,0,1 repeating → addr_vld only after en=1 edges. Address sequence identical to the single-frame case, 448 addresses total, addr/stage held during gaps.
- Continuous:
  - continuous=1 for two frames → 896 addresses with no bubble, sync at address 1 and 449, no done at 448.
  - Drop continuous during frame 2 → done at address 896, then IDLE.
- Abort mid-frame: abort at address 100 (stage 1) → next cycle addr_vld=0, busy=0, no done. A new start then produces a fresh frame beginning with sync and addr 0.
- Start while busy / at frame end: start pulses during RUN and on the done cycle are ignored, and exactly 448 addresses are issued. A start one cycle after done begins a new frame.
